fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives a word-aligned byte address to the memory every cycle. It captures the memory's registered read data one cycle later and delivers (instruction, PC) pairs to decode over a valid/ready handshake. A 2-entry buffer absorbs the fixed one-cycle memory latency so that backpressure and redirects never lose or duplicate an instruction.

## Interface
- A_WIDTH, 32: PC / byte-address width.
- D_WIDTH, 32: instruction width; PC step is D_WIDTH/8 bytes (4).
- RESET_PC, 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  when high, new fetches may issue; when low, none issue and in-flight fetches still complete.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  A_WIDTH  new PC; bits [1:0] are ignored and forced to 0.
- imem_addr  out  A_WIDTH  byte address to instruction memory; equals pc_q.
- imem_rdata  in  D_WIDTH  memory read data; valid the cycle after imem_addr was presented.
- out_valid  out  1  an instruction is available to decode.
- out_ready  in  1  decode accepts it this cycle.
- out_instr  out  D_WIDTH  instruction at buffer head.
- out_pc  out  A_WIDTH  PC of out_instr.

## Operation
- State: pc_q, req_vld_q (a fetch is in flight), req_pc_q (its PC), and a 2-entry FIFO of {instr, pc}.
- Pop: out_valid & out_ready.
- Issue condition: fetch_en & ~redirect_valid & (count + req_vld_q − pop < 2).
- On issue: req_vld_q←1, req_pc_q←pc_q, pc_q←pc_q + 4. Otherwise req_vld_q←0 and pc_q holds.
- Response: if req_vld_q, push {imem_rdata, req_pc_q} into the FIFO at the end of this cycle.
- out_valid = FIFO non-empty. out_instr and out_pc are the head entry.
- Redirect (redirect_valid=1): FIFO is emptied, req_vld_q←0 (the in-flight response is dropped), pc_q←{redirect_pc[A_WIDTH-1:2],2'b00}, and nothing issues this cycle.
- A pop coinciding with a redirect counts as a completed transfer to decode; the remaining contents are flushed.
- PC arithmetic is modulo 2^A_WIDTH: 0xFFFF_FFFC + 4 → 0x0000_0000, with no error flag.
- Simultaneous push and pop with count=2 cannot occur, because the issue condition guarantees room. FIFO overflow is an assertion failure.
- fetch_en low with a fetch in flight: the response is still pushed and delivered.

## Timing
- Reset values: pc_q=RESET_PC (so imem_addr=RESET_PC), req_vld_q=0, req_pc_q=0, FIFO empty, out_valid=0, out_instr=0, out_pc=0.
- Reset is applied asynchronously, with synchronous deassert assumed at the system level. Asserting reset mid-operation discards all in-flight and buffered instructions immediately.
- Latency: address presented in cycle N → data on imem_rdata in N+1 → out_valid in N+2.
- First out_valid: the second rising edge after rst deasserts, with fetch_en=1.
- Throughput: 1 instruction/cycle with out_ready held high.
- Redirect pulse in cycle R → imem_addr=redirect_pc in R+1 → out_valid with out_pc=redirect_pc in R+3. out_valid=0 in R+1 and R+2.
- Backpressure: out_instr and out_pc are held stable while out_valid & ~out_ready. With ready low, at most 2 entries are buffered and issuing stops.

## Structure
- Shared package: INSTR_BYTES (=D_WIDTH/8) and the default RESET_PC constant, both also used by the branch unit.
- One sub-module: fetch_fifo, a 2-entry synchronous FIFO with push, pop, flush, count, head data, and async active-low reset. Entry width is D_WIDTH+A_WIDTH.

## Test plan
- Reset then free-run: preload mem[i]=0x1000_0000+i, RESET_PC=0, out_ready=1 → out_pc=0,4,8,… every cycle from the 2nd edge after reset, with out_instr matching.
- Backpressure: drop out_ready for 5 cycles mid-stream → out_pc/out_instr held, no more than 2 entries buffered, and the sequence resumes with no gap or duplicate.
- Redirect: pulse redirect_valid with redirect_pc=0x43 while streaming → exactly 2 bubble cycles, then out_pc=0x40, 0x44, …; no stale instruction appears.
- Redirect coinciding with pop, with a full FIFO and out_ready=1 → the popped instruction is counted once, then the next out_pc equals the redirect target.
- Wrap-around: redirect to 0xFFFF_FFF8 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- fetch_en low for 4 cycles, then reset asserted mid-stream → the in-flight instruction is still delivered and imem_addr holds; on reset, out_valid drops to 0 immediately and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, also consumed by the branch unit.
package fetch_unit_pkg;

    localparam int A_WIDTH_DEF = 32;
    localparam int D_WIDTH_DEF = 32;
    localparam int INSTR_BYTES = D_WIDTH_DEF / 8;
    localparam int FIFO_DEPTH  = 2;

    localparam logic [A_WIDTH_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode handshake.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
);

    logic [A_WIDTH-1:0] imem_addr;
    logic [D_WIDTH-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_instr;
    logic [A_WIDTH-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO that buffers returning fetches; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] entries_q [FIFO_DEPTH];
    logic [WIDTH-1:0] entries_d [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                entries_d[wr_ptr_q] = push_data_i;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    // NOTE: the storage is reset too, so the head reads as all-zero out of reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entries_q[rd_ptr_q];

    overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));

    underflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word-aligned reads and hands (instr, pc) pairs to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 A_WIDTH  = A_WIDTH_DEF,
    parameter int                 D_WIDTH  = D_WIDTH_DEF,
    parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    fetch_unit_if.master       bus
);

    typedef struct packed {
        logic [D_WIDTH-1:0] instr;
        logic [A_WIDTH-1:0] pc;
    } entry_t;

    localparam logic [A_WIDTH-1:0] PC_STEP    = A_WIDTH'(INSTR_BYTES);
    localparam logic [A_WIDTH-1:0] ALIGN_MASK = ~(PC_STEP - 1'b1);

    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic [A_WIDTH-1:0] req_pc_q, req_pc_d;
    logic               req_vld_q, req_vld_d;

    logic               pop;
    logic               push;
    logic               issue;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;
    entry_t             push_entry;
    entry_t             head;

    assign pop = bus.out_valid & bus.out_ready;

    // Slots already promised: buffered entries plus the in-flight read, less the one leaving now.
    assign occupancy = 3'(fifo_count) + 3'(req_vld_q) - 3'(pop);
    assign issue     = fetch_en & ~redirect_valid & (occupancy < 3'(FIFO_DEPTH));

    // A redirect drops the response of the fetch issued before it.
    assign push = req_vld_q & ~redirect_valid;

    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_vld_d = issue;
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
        end else if (issue) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            req_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            req_vld_q <= req_vld_d;
        end
    end

    assign push_entry = '{instr: bus.imem_rdata, pc: req_pc_q};

    fetch_fifo #(
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the model predicts the delivered PC stream from resets and redirects.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_pc;
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    fetch_unit_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

    fetch_unit #(
        .A_WIDTH  (AW),
        .D_WIDTH  (DW),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Instruction memory with a one-cycle registered read.
    always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decode must see consecutive words from the last reset or redirect target.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            model_pc = RST_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    end

    // Monitor: compares every accepted transfer and checks stability under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_pc", bus.out_pc, prev_pc);
                check("hold_instr", bus.out_instr, prev_instr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %h, expected no transfer", bus.out_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("sb_pc", bus.out_pc, exp_pc);
                    check("sb_instr", bus.out_instr, mem_word(exp_pc));
                end
                n_pop++;
                last_pc = bus.out_pc;
            end
            prev_stall = bus.out_valid && !bus.out_ready && !redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          p0;
        logic [31:0] hold_addr;
        logic [31:0] w;

        rst            = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = 1'b0;

        #2;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr", bus.imem_addr, RST_PC);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);

        // Free run from reset.
        cyc(2);
        rst           = 1'b1;
        fetch_en      = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("first_edge0_valid", 32'(bus.out_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        check("first_edge1_valid", 32'(bus.out_valid), 32'd0);
        check("first_edge1_addr", bus.imem_addr, RST_PC + 32'd4);
        cyc(1);
        @(negedge clk);
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_pc", bus.out_pc, RST_PC);
        cyc(1);
        p0 = n_pop;
        cyc(20);
        check("throughput", n_pop - p0, 32'd20);

        // Backpressure: buffer fills to two entries and issuing stops.
        bus.out_ready = 1'b0;
        cyc(5);
        @(negedge clk);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_addr", bus.imem_addr, bus.out_pc + 32'd8);
        cyc(1);
        bus.out_ready = 1'b1;
        p0 = n_pop;
        cyc(10);
        check("resume_rate", n_pop - p0, 32'd10);

        // Redirect to an unaligned target: two bubbles, then the aligned target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        cyc(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_bubble1", 32'(bus.out_valid), 32'd0);
        check("redir_addr", bus.imem_addr, 32'h0000_0040);
        cyc(1);
        @(negedge clk);
        check("redir_bubble2", 32'(bus.out_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        check("redir_valid", 32'(bus.out_valid), 32'd1);
        check("redir_pc", bus.out_pc, 32'h0000_0040);
        cyc(5);

        // Redirect coinciding with a pop from a full buffer.
        bus.out_ready = 1'b0;
        cyc(4);
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        p0 = n_pop;
        cyc(1);
        redirect_valid = 1'b0;
        check("redir_pop_once", n_pop - p0, 32'd1);
        cyc(2);
        @(negedge clk);
        check("redir_pop_target", bus.out_pc, 32'h0000_0200);
        cyc(4);

        // Wrap-around at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);
        for (int k = 0; k < 4; k++) begin
            w = 32'hFFFF_FFF8 + 32'(4 * k);
            @(negedge clk);
            check("wrap_pc", bus.out_pc, w);
            cyc(1);
        end
        cyc(4);

        // fetch_en low: in-flight fetch completes, address holds, stream drains.
        fetch_en = 1'b0;
        @(negedge clk);
        hold_addr = bus.out_pc + 32'd8;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check("fen_addr_hold", bus.imem_addr, hold_addr);
            cyc(1);
        end
        check("fen_drained", 32'(bus.out_valid), 32'd0);
        check("fen_last_pc", last_pc, hold_addr - 32'd4);

        // Reset mid-stream takes effect immediately.
        fetch_en = 1'b1;
        cyc(6);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_addr", bus.imem_addr, RST_PC);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        @(negedge clk);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_pc", bus.out_pc, RST_PC);
        cyc(1);

        // Randomized traffic checked by the scoreboard.
        p0 = n_pop;
        for (int i = 0; i < 400; i++) begin
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            cyc(1);
        end
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        bus.out_ready  = 1'b1;
        cyc(10);
        check("random_progress", 32'(n_pop - p0 >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
